// File: rtl/interconnect_sfft_pkg.sv
// Shared FSM encoding and frame-size helpers for the sFFT even/odd recombiner.
// Optional feature macro: INTERCONNECT_SFFT_OVF_ERR_EN (overflow error flag).
package interconnect_sfft_pkg;

  typedef enum logic [1:0] {
    BUF_A  = 2'd0,
    EMIT_A = 2'd1,
    EMIT_B = 2'd2
  } sfft_state_e;

  function automatic int nfft_size(input int size_buffer);
    return 1 << size_buffer;
  endfunction

  function automatic int half_size(input int size_buffer);
    return (1 << size_buffer) / 2;
  endfunction

  // A single-entry half still needs a 1-bit address to index the array.
  function automatic int addr_width(input int size_buffer);
    return (size_buffer > 1) ? size_buffer - 1 : 1;
  endfunction

endpackage

// File: rtl/interconnect_sfft_to_data_if.sv
// Stream bundle between the sFFT splitter output and the recombiner.
// Optional feature macro: INTERCONNECT_SFFT_OVF_ERR_EN adds ovf_err.
interface interconnect_sfft_to_data_if #(
  parameter int SIZE_BUFFER   = 1,
  parameter int DATA_FFT_SIZE = 16
);
  logic [DATA_FFT_SIZE-1:0] in_data_i;
  logic [DATA_FFT_SIZE-1:0] in_data_q;
  logic                     valid;
  logic                     in_ready;
  logic [DATA_FFT_SIZE-1:0] out_data_i;
  logic [DATA_FFT_SIZE-1:0] out_data_q;
  logic                     outvalid;
  logic [SIZE_BUFFER:0]     counter_data;
  logic                     frame_done;
`ifdef INTERCONNECT_SFFT_OVF_ERR_EN
  logic                     ovf_err;
`endif

  modport master (
    output in_data_i, in_data_q, valid,
    input  in_ready, out_data_i, out_data_q, outvalid, counter_data, frame_done
`ifdef INTERCONNECT_SFFT_OVF_ERR_EN
    , input ovf_err
`endif
  );

  modport slave (
    input  in_data_i, in_data_q, valid,
    output in_ready, out_data_i, out_data_q, outvalid, counter_data, frame_done
`ifdef INTERCONNECT_SFFT_OVF_ERR_EN
    , output ovf_err
`endif
  );

endinterface

// File: rtl/sfft_half_buffer.sv
// Half-frame sample store: one write port, one registered read port, no reset.
// A same-address read during a write returns the new data (single-entry case).
module sfft_half_buffer #(
  parameter int DEPTH = 1,
  parameter int AW    = 1,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata_q <= wdata;
    end else begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/interconnect_sfft_to_data.sv
// Recombines split sFFT halves (A = even, B = odd) into natural order A0,B0,A1,B1,...
// Optional feature macro: INTERCONNECT_SFFT_OVF_ERR_EN (sticky ovf_err on valid while not ready).
module interconnect_sfft_to_data
  import interconnect_sfft_pkg::*;
#(
  parameter int SIZE_BUFFER   = 1,
  parameter int DATA_FFT_SIZE = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  interconnect_sfft_to_data_if.slave  bus
);

  localparam int HALF  = half_size(SIZE_BUFFER);
  localparam int CNT_W = SIZE_BUFFER;
  localparam int AW    = addr_width(SIZE_BUFFER);
  localparam int DW    = 2 * DATA_FFT_SIZE;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HALF - 1);

  sfft_state_e state_q, state_d;

  logic [CNT_W-1:0]         wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]         rd_cnt_q, rd_cnt_d;
  logic [DW-1:0]            hold_q, hold_d;
  logic [DATA_FFT_SIZE-1:0] out_i_q, out_i_d;
  logic [DATA_FFT_SIZE-1:0] out_q_q, out_q_d;
  logic                     outvalid_q, outvalid_d;
  logic                     frame_done_q, frame_done_d;
  logic [SIZE_BUFFER:0]     counter_q, counter_d;

  logic          in_ready;
  logic          accept;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [AW-1:0] buf_raddr;
  logic [DW-1:0] buf_rdata;

  assign accept = bus.valid & in_ready;
  assign buf_we = accept & (state_q == BUF_A);

  // Read address follows the next rd_cnt so A[rd_cnt] is already registered on entry to EMIT_A.
  if (SIZE_BUFFER == 1) begin : g_addr_single
    assign buf_waddr = '0;
    assign buf_raddr = '0;
  end else begin : g_addr_multi
    assign buf_waddr = wr_cnt_q[AW-1:0];
    assign buf_raddr = rd_cnt_d[AW-1:0];
  end

  sfft_half_buffer #(
    .DEPTH (HALF),
    .AW    (AW),
    .DW    (DW)
  ) u_half_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata ({bus.in_data_i, bus.in_data_q}),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BUF_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_A: begin
        if (accept && (wr_cnt_q == LAST_IDX)) begin
          state_d = EMIT_A;
        end
      end
      EMIT_A: begin
        if (accept) begin
          state_d = EMIT_B;
        end
      end
      EMIT_B: begin
        state_d = (rd_cnt_q < LAST_IDX) ? EMIT_A : BUF_A;
      end
      default: state_d = BUF_A;
    endcase
  end

  always_comb begin
    in_ready = 1'b1;
    if (state_q == EMIT_B) begin
      in_ready = 1'b0;
    end
  end

  always_comb begin
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    hold_d       = hold_q;
    out_i_d      = out_i_q;
    out_q_d      = out_q_q;
    counter_d    = counter_q;
    outvalid_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      BUF_A: begin
        if (accept) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (wr_cnt_q == LAST_IDX) begin
            rd_cnt_d = '0;
          end
        end
      end
      EMIT_A: begin
        if (accept) begin
          out_i_d    = buf_rdata[DW-1:DATA_FFT_SIZE];
          out_q_d    = buf_rdata[DATA_FFT_SIZE-1:0];
          counter_d  = {rd_cnt_q, 1'b0};
          outvalid_d = 1'b1;
          hold_d     = {bus.in_data_i, bus.in_data_q};
        end
      end
      EMIT_B: begin
        out_i_d    = hold_q[DW-1:DATA_FFT_SIZE];
        out_q_d    = hold_q[DATA_FFT_SIZE-1:0];
        counter_d  = {rd_cnt_q, 1'b1};
        outvalid_d = 1'b1;
        rd_cnt_d   = rd_cnt_q + CNT_W'(1);
        if (rd_cnt_q == LAST_IDX) begin
          frame_done_d = 1'b1;
          wr_cnt_d     = '0;
        end
      end
      default: begin
        wr_cnt_d = '0;
        rd_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      hold_q       <= '0;
      out_i_q      <= '0;
      out_q_q      <= '0;
      counter_q    <= '0;
      outvalid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      hold_q       <= hold_d;
      out_i_q      <= out_i_d;
      out_q_q      <= out_q_d;
      counter_q    <= counter_d;
      outvalid_q   <= outvalid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_data_i   = out_i_q;
  assign bus.out_data_q   = out_q_q;
  assign bus.outvalid     = outvalid_q;
  assign bus.counter_data = counter_q;
  assign bus.frame_done   = frame_done_q;

`ifdef INTERCONNECT_SFFT_OVF_ERR_EN
  logic ovf_err_q, ovf_err_d;

  always_comb begin
    ovf_err_d = ovf_err_q | (bus.valid & ~in_ready);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
    end
  end

  assign bus.ovf_err = ovf_err_q;
`endif

endmodule

// File: doc/interconnect_sfft_to_data.md
INTERCONNECT_SFFT_TO_DATA -- requirements
Module: interconnect_sfft_to_data

Interface
REQ-001 SHALL have parameter SIZE_BUFFER, default 1; log2(NFFT), NFFT = 1<<SIZE_BUFFER, with each half-block NFFT/2 samples.
REQ-002 SHALL have parameter DATA_FFT_SIZE, default 16; width of each I and Q sample.
REQ-003 SHALL have port clk, input, 1; the single clock, with all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1; asynchronous, active-low reset.
REQ-005 SHALL have port in_data_i / in_data_q, input, DATA_FFT_SIZE each; sFFT result samples.
REQ-006 SHALL have port valid, input, 1; input sample qualifier.
REQ-007 SHALL have port in_ready, output, 1; high = block accepts a sample this cycle; a transfer occurs when valid & in_ready.
REQ-008 SHALL have port out_data_i / out_data_q, output, DATA_FFT_SIZE each; recombined stream.
REQ-009 SHALL have port outvalid, output, 1; output sample qualifier, with no backpressure on the output.
REQ-010 SHALL have port counter_data, output, SIZE_BUFFER+1; natural index 0..NFFT-1 of the current output sample.
REQ-011 SHALL have port frame_done, output, 1; one-cycle pulse coincident with the output of index NFFT-1.

Function
REQ-012 SHALL operate as the inverse of the even/odd splitter: the first NFFT/2 accepted samples form half A (even indices) and the next NFFT/2 form half B (odd indices).
REQ-013 SHALL output the interleaved sequence A0,B0,A1,B1,...,A(N/2-1),B(N/2-1) with counter_data = 0..NFFT-1.
REQ-014 SHALL implement states BUF_A, EMIT_A and EMIT_B.
REQ-015 In BUF_A, SHALL drive in_ready=1 and outvalid=0, write each accepted sample to buffer[wr_cnt], and increment wr_cnt.
REQ-016 On acceptance of the sample with wr_cnt==NFFT/2-1, SHALL clear rd_cnt and move to EMIT_A.
REQ-017 In EMIT_A, SHALL drive in_ready=1.
REQ-018 In EMIT_A, on acceptance, SHALL register A[rd_cnt] to the outputs with outvalid=1 the next cycle, latch the B sample into a holding register, and move to EMIT_B.
REQ-019 In EMIT_B, SHALL drive in_ready=0, output the held B sample with outvalid=1, and increment rd_cnt.
REQ-020 From EMIT_B, SHALL return to EMIT_A if rd_cnt < NFFT/2-1; otherwise it SHALL pulse frame_done, clear wr_cnt and return to BUF_A.
REQ-021 Latency SHALL be one cycle from B-sample acceptance to A output, and two cycles to B output.
REQ-022 Throughput in phase B SHALL be one input per two cycles.
REQ-023 SHALL retain its state when valid=0 in any state, with outvalid=0 except in EMIT_B.
REQ-024 SHALL ignore valid when in_ready=0, with no write and no state change.
REQ-025 SHALL hold out_data_* at their last value when outvalid=0.
REQ-026 SHALL wrap wr_cnt and rd_cnt only via the explicit clears; the counters SHALL never exceed NFFT/2.
REQ-027 SHALL work for SIZE_BUFFER=1: a single-entry buffer and a 2-sample output frame.

Reset
REQ-028 Asserting reset (low) at any time, including mid-frame, SHALL asynchronously force state=BUF_A, wr_cnt=rd_cnt=0, in_ready=1, outvalid=0, frame_done=0, counter_data=0 and out_data_*=0, and SHALL discard the partial frame.
REQ-029 Buffer contents SHALL NOT require reset.
REQ-030 Outputs SHALL resume on the first clk edge after deassertion.

Configuration
REQ-031 SHALL support the macro INTERCONNECT_SFFT_OVF_ERR_EN: when defined, it adds an output ovf_err, 1 bit, a sticky flag set when valid=1 while in_ready=0 and cleared only by reset.
REQ-032 With INTERCONNECT_SFFT_OVF_ERR_EN undefined, the ovf_err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 SHALL place the state encodings (BUF_A, EMIT_A, EMIT_B) and the NFFT/half-size derivation helpers in the shared package interconnect_sfft_pkg.
REQ-034 SHALL implement the NFFT/2 x 2*DATA_FFT_SIZE storage as the sub-module sfft_half_buffer: a single write port, a single synchronous read port and no reset.

Verification (SIZE_BUFFER=3, NFFT=8, DATA_FFT_SIZE=16)
REQ-035 Continuous valid with inputs I=0..7 (Q=100+I) SHALL produce outputs I=0,4,1,5,2,6,3,7 with counter_data 0..7, frame_done at index 7 only, and in_ready low in each EMIT_B cycle.
REQ-036 Random valid gaps in both halves SHALL produce the same output order, with no output during gaps, and with in_ready and the counters stable while idle.
REQ-037 Two back-to-back frames (inputs 0..15) SHALL produce 0,4,1,5,2,6,3,7 then 8,12,9,13,10,14,11,15, with the second frame's BUF_A starting the cycle after frame_done.
REQ-038 Reset low after 6 accepted samples (during EMIT_A) SHALL immediately give outvalid=0 and in_ready=1, and the next frame of 20..27 SHALL emit 20,24,21,25,... correctly.
REQ-039 With INTERCONNECT_SFFT_OVF_ERR_EN defined, valid held high during EMIT_B SHALL set ovf_err, which stays set until reset while the data order remains correct; without the macro, the same stimulus SHALL produce the same data and no ovf_err port.
REQ-040 With SIZE_BUFFER=1 and inputs 5,9, the outputs SHALL be 5,9 with frame_done on 9.
